// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal synchronization tree.
package fractal_sync_pkg;

    typedef enum logic {
        FSYNC_ARB_RR    = 1'b0,
        FSYNC_ARB_FIXED = 1'b1
    } fsync_arb_mode_e;

endpackage : fractal_sync_pkg

// File: rtl/fractal_sync_out_slot.sv
// One-entry valid/ready output register; avail_c_o is high when a new element can be loaded this cycle.
module fractal_sync_out_slot #(
    parameter type fsync_t = logic
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   load_i,
    input  logic   ready_i,
    input  fsync_t data_i,
    output logic   avail_c_o,
    output logic   valid_o,
    output fsync_t data_o
);

    logic   valid_q, valid_d;
    fsync_t data_q, data_d;

    // Slot is free when empty or being drained this cycle.
    assign avail_c_o = ~valid_q | ready_i;

    // Load beats drain; an accepted element with no replacement clears the slot.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
            data_d  = '0;
        end
    end

    // Slot state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

    // A stalled element must not change under the downstream consumer.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_q && !ready_i) |=> (data_q == $past(data_q)))
        else $error("out_slot: data changed while stalled");

endmodule : fractal_sync_out_slot

// File: rtl/fractal_sync_mp_arbiter.sv
// Multi-in/multi-out arbiter: drains up to OUT_PORTS FIFO heads per cycle in round-robin or fixed priority.
module fractal_sync_mp_arbiter
    import fractal_sync_pkg::*;
#(
    parameter int unsigned IN_PORTS  = 4,
    parameter int unsigned OUT_PORTS = 2,
    parameter type         fsync_t   = logic
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  fsync_arb_mode_e      mode_i,
    input  logic [IN_PORTS-1:0]  empty_i,
    input  fsync_t               element_i [IN_PORTS],
    output logic [IN_PORTS-1:0]  pop_o,
    output logic [OUT_PORTS-1:0] valid_o,
    input  logic [OUT_PORTS-1:0] ready_i,
    output fsync_t               element_o [OUT_PORTS]
);

    localparam int unsigned PTR_W = (IN_PORTS > 1) ? $clog2(IN_PORTS) : 1;

    if (IN_PORTS == 0 || OUT_PORTS == 0) begin : g_bad_param
        $fatal(1, "fractal_sync_mp_arbiter: IN_PORTS and OUT_PORTS must be > 0");
    end

    logic [IN_PORTS-1:0]  req;
    logic [IN_PORTS-1:0]  gnt;
    logic [OUT_PORTS-1:0] avail;
    logic [OUT_PORTS-1:0] load;
    logic [PTR_W-1:0]     sel   [OUT_PORTS];
    logic [PTR_W-1:0]     order [IN_PORTS];
    logic [PTR_W-1:0]     base;
    logic [PTR_W-1:0]     last_gnt;
    logic                 any_gnt;
    logic [PTR_W-1:0]     ptr_q, ptr_d;

    // Modular add without relying on counter overflow (IN_PORTS need not be a power of two).
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] b, input int unsigned k);
        int unsigned sum;
        sum = 32'(b) + k;
        if (sum >= IN_PORTS) begin
            sum = sum - IN_PORTS;
        end
        return PTR_W'(sum);
    endfunction

    // No requests are seen while reset is asserted, so nothing is popped.
    assign req = ~empty_i & {IN_PORTS{rst_ni}};

    // Search order: rotating from ptr_q in RR mode, from input 0 in fixed mode.
    always_comb begin
        base = (mode_i == FSYNC_ARB_RR) ? ptr_q : '0;
        for (int k = 0; k < IN_PORTS; k++) begin
            order[k] = wrap_add(base, 32'(k));
        end
    end

    // Allocation: each free output, in ascending order, takes the next ungranted requester.
    always_comb begin
        gnt      = '0;
        load     = '0;
        last_gnt = ptr_q;
        any_gnt  = 1'b0;
        for (int i = 0; i < OUT_PORTS; i++) begin
            sel[i] = '0;
        end
        for (int i = 0; i < OUT_PORTS; i++) begin
            if (avail[i]) begin
                for (int k = 0; k < IN_PORTS; k++) begin
                    if (!load[i] && req[order[k]] && !gnt[order[k]]) begin
                        gnt[order[k]] = 1'b1;
                        load[i]       = 1'b1;
                        sel[i]        = order[k];
                        last_gnt      = order[k];
                        any_gnt       = 1'b1;
                    end
                end
            end
        end
    end

    assign pop_o = gnt;

    // Pointer moves past the last granted input in RR mode; holds otherwise.
    always_comb begin
        ptr_d = ptr_q;
        if (mode_i == FSYNC_ARB_RR && any_gnt) begin
            ptr_d = (last_gnt == PTR_W'(IN_PORTS - 1)) ? '0 : last_gnt + PTR_W'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    for (genvar i = 0; i < OUT_PORTS; i++) begin : g_slot
        fractal_sync_out_slot #(
            .fsync_t (fsync_t)
        ) u_slot (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .load_i    (load[i]),
            .ready_i   (ready_i[i]),
            .data_i    (element_i[sel[i]]),
            .avail_c_o (avail[i]),
            .valid_o   (valid_o[i]),
            .data_o    (element_o[i])
        );
    end

    // A pop must only target a non-empty FIFO.
    assert property (@(posedge clk_i) disable iff (!rst_ni) ((pop_o & empty_i) == '0))
        else $error("mp_arbiter: pop issued to empty FIFO");

endmodule : fractal_sync_mp_arbiter

// File: tb/tb_fractal_sync_mp_arbiter.sv
// Directed bench for fractal_sync_mp_arbiter (IN_PORTS=4, OUT_PORTS=2, 8-bit elements).
module tb_fractal_sync_mp_arbiter;
    import fractal_sync_pkg::*;

    logic            clk_i;
    logic            rst_ni;
    fsync_arb_mode_e mode_i;
    logic [3:0]      empty_i;
    logic [7:0]      element_i [4];
    logic [3:0]      pop_o;
    logic [1:0]      valid_o;
    logic [1:0]      ready_i;
    logic [7:0]      element_o [2];

    logic [3:0]      hd [4];
    logic [3:0]      last_pop;
    int              cnt [4];
    int              n_checks;
    int              n_fail;

    fractal_sync_mp_arbiter #(
        .IN_PORTS  (4),
        .OUT_PORTS (2),
        .fsync_t   (logic [7:0])
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .mode_i    (mode_i),
        .empty_i   (empty_i),
        .element_i (element_i),
        .pop_o     (pop_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .element_o (element_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: present FIFO heads, check pops mid-cycle, then check registered outputs after the edge.
    task automatic cyc(input string tag, input logic [3:0] ep, input logic [1:0] ev,
                       input logic [7:0] e0, input logic [7:0] e1, input logic [1:0] eptr);
        for (int j = 0; j < 4; j++) begin
            element_i[j] = {4'(j), hd[j]};
        end
        #1;
        last_pop = pop_o;
        check_eq({tag, ".pop"}, 32'(pop_o), 32'(ep));
        @(posedge clk_i);
        for (int j = 0; j < 4; j++) begin
            if (ep[j]) hd[j] = hd[j] + 4'd1;
        end
        #1;
        check_eq({tag, ".valid"}, 32'(valid_o), 32'(ev));
        check_eq({tag, ".e0"}, 32'(element_o[0]), 32'(e0));
        check_eq({tag, ".e1"}, 32'(element_o[1]), 32'(e1));
        check_eq({tag, ".ptr"}, 32'(dut.ptr_q), 32'(eptr));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int j = 0; j < 4; j++) begin
            hd[j]  = 4'd0;
            cnt[j] = 0;
        end
        rst_ni  = 1'b0;
        mode_i  = FSYNC_ARB_RR;
        empty_i = 4'b0000;
        ready_i = 2'b11;
        #2;

        // Reset held with all inputs requesting.
        for (int n = 0; n < 3; n++) begin
            cyc("reset", 4'b0000, 2'b00, 8'h00, 8'h00, 2'd0);
        end
        rst_ni = 1'b1;

        // RR fairness: pairs {0,1},{2,3} alternate.
        for (int n = 0; n < 8; n++) begin
            if (n % 2 == 0) begin
                cyc("rr_fair", 4'b0011, 2'b11, {4'h0, 4'(n / 2)}, {4'h1, 4'(n / 2)}, 2'd2);
            end else begin
                cyc("rr_fair", 4'b1100, 2'b11, {4'h2, 4'(n / 2)}, {4'h3, 4'(n / 2)}, 2'd0);
            end
            for (int j = 0; j < 4; j++) cnt[j] += int'(last_pop[j]);
        end
        for (int j = 0; j < 4; j++) begin
            check_eq("rr_share", 32'(cnt[j]), 32'd4);
        end

        // Single requester (input 2): always out0, pointer parks at 3.
        empty_i = 4'b1011;
        cyc("single", 4'b0100, 2'b01, 8'h24, 8'h00, 2'd3);
        cyc("single", 4'b0100, 2'b01, 8'h25, 8'h00, 2'd3);
        cyc("single", 4'b0100, 2'b01, 8'h26, 8'h00, 2'd3);

        // RR wrap from ptr 3 with inputs 3 and 1.
        empty_i = 4'b0101;
        cyc("rr_wrap", 4'b1010, 2'b11, 8'h34, 8'h14, 2'd2);

        // Fixed priority: 0 and 2 win, 3 starves, pointer held.
        mode_i  = FSYNC_ARB_FIXED;
        empty_i = 4'b0010;
        cyc("fixed", 4'b0101, 2'b11, 8'h04, 8'h27, 2'd2);
        cyc("fixed", 4'b0101, 2'b11, 8'h05, 8'h28, 2'd2);
        cyc("fixed", 4'b0101, 2'b11, 8'h06, 8'h29, 2'd2);

        // Back to RR resumes from held pointer 2.
        mode_i = FSYNC_ARB_RR;
        cyc("rr_resume", 4'b1100, 2'b11, 8'h2a, 8'h35, 2'd0);

        // Backpressure on out1: it holds, out0 takes one pop per cycle.
        empty_i = 4'b0000;
        ready_i = 2'b01;
        cyc("bp", 4'b0001, 2'b11, 8'h07, 8'h35, 2'd1);
        cyc("bp", 4'b0010, 2'b11, 8'h15, 8'h35, 2'd2);
        cyc("bp", 4'b0100, 2'b11, 8'h2b, 8'h35, 2'd3);
        cyc("bp", 4'b1000, 2'b11, 8'h36, 8'h35, 2'd0);
        ready_i = 2'b11;
        cyc("bp_release", 4'b0011, 2'b11, 8'h08, 8'h16, 2'd2);

        // All empty: slots drain, pointer holds.
        empty_i = 4'b1111;
        cyc("drain", 4'b0000, 2'b00, 8'h00, 8'h00, 2'd2);

        // All stalled: load once into free slots, then nothing moves.
        empty_i = 4'b0000;
        ready_i = 2'b00;
        cyc("stall_fill", 4'b1100, 2'b11, 8'h2c, 8'h37, 2'd0);
        cyc("stall", 4'b0000, 2'b11, 8'h2c, 8'h37, 2'd0);
        cyc("stall", 4'b0000, 2'b11, 8'h2c, 8'h37, 2'd0);

        // Reset with held elements discards them.
        rst_ni = 1'b0;
        cyc("reset_mid", 4'b0000, 2'b00, 8'h00, 8'h00, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fractal_sync_mp_arbiter
